// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes and default datapath width.
// Imported by the ALU and by the ALU front-end arbiter.
package alu_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;

  // Modular increment that stays inside [0, n-1] for any n.
  function automatic int wrap_inc(input int v, input int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin priority picker: first asserted request at or after
// the pointer, wrapping modulo N. Pure combinational.
module rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  input  logic             i_en,
  output logic [N-1:0]     o_gnt,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  int w_c;

  // Scan from farthest to nearest so the nearest hit wins.
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_c   = 0;
    for (int k = N - 1; k >= 0; k--) begin
      w_c = int'(i_ptr) + k;
      if (w_c >= N) begin
        w_c = w_c - N;
      end
      if (i_en && i_req[w_c[IDX_W-1:0]]) begin
        o_idx = w_c[IDX_W-1:0];
        o_any = 1'b1;
      end
    end
    if (o_any) begin
      o_gnt[o_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU among NUM_REQ requesters with round-robin grant
// and a single registered response slot.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int XLEN    = XLEN_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*XLEN-1:0] req_a,
  input  logic [NUM_REQ*XLEN-1:0] req_b,
  input  logic [NUM_REQ*4-1:0]    req_op,
  output logic [XLEN-1:0]         alu_a,
  output logic [XLEN-1:0]         alu_b,
  output logic [3:0]              alu_ctrl,
  input  logic [XLEN-1:0]         alu_result,
  input  logic                    alu_zero,
  output logic [NUM_REQ-1:0]      rsp_valid,
  input  logic [NUM_REQ-1:0]      rsp_ready,
  output logic [XLEN-1:0]         rsp_result,
  output logic                    rsp_zero
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0] r_rsp_valid;
  logic [XLEN-1:0]    r_rsp_result;
  logic               r_rsp_zero;
  logic [IDX_W-1:0]   r_rr_ptr;

  logic               w_drain;
  logic               w_slot_free;
  logic               w_en;
  logic [NUM_REQ-1:0] w_gnt;
  logic [IDX_W-1:0]   w_idx;
  logic               w_any;
  logic [IDX_W-1:0]   w_next_ptr;

  assign w_drain     = |(r_rsp_valid & rsp_ready);
  assign w_slot_free = ~(|r_rsp_valid) | w_drain;
  assign w_en        = w_slot_free & ~rst;

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .i_req (req_valid),
    .i_ptr (r_rr_ptr),
    .i_en  (w_en),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  assign req_ready = w_gnt;

  // One-hot AND-OR mux; idle drives a harmless AND of zeros.
  always_comb begin
    alu_a    = '0;
    alu_b    = '0;
    alu_ctrl = OP_AND;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt[i]) begin
        alu_a    = req_a[i*XLEN +: XLEN];
        alu_b    = req_b[i*XLEN +: XLEN];
        alu_ctrl = req_op[i*4 +: 4];
      end
    end
  end

  assign w_next_ptr = (w_idx == IDX_W'(NUM_REQ - 1)) ?
                      '0 : w_idx + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_valid  <= '0;
      r_rsp_result <= '0;
      r_rsp_zero   <= 1'b0;
      r_rr_ptr     <= '0;
    end else if (w_any) begin
      r_rsp_valid  <= w_gnt;
      r_rsp_result <= alu_result;
      r_rsp_zero   <= alu_zero;
      r_rr_ptr     <= w_next_ptr;
    end else if (w_drain) begin
      r_rsp_valid  <= '0;
    end
  end

  assign rsp_valid  = r_rsp_valid;
  assign rsp_result = r_rsp_result;
  assign rsp_zero   = r_rsp_zero;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a 2-requester and a 3-requester instance
// share stimulus and are checked against an abstract model.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  req_valid = '0;
  logic [2:0]  rsp_ready = '0;
  logic [95:0] req_a = '0;
  logic [95:0] req_b = '0;
  logic [11:0] req_op = '0;

  logic [1:0]  rdy2, rv2;
  logic [2:0]  rdy3, rv3;
  logic [31:0] aa2, ab2, ares2, res2;
  logic [31:0] aa3, ab3, ares3, res3;
  logic [3:0]  ctl2, ctl3;
  logic        az2, z2, az3, z3;

  int n_tests = 0;
  int n_fail  = 0;

  int m_own [2];
  int m_ptr [2];
  logic [31:0] m_res [2];
  logic m_zero [2];
  int last_g [2];

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_ref(
    input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    case (op)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      default: return 32'd0;
    endcase
  endfunction

  assign ares2 = alu_ref(aa2, ab2, ctl2);
  assign az2   = (ares2 == 32'd0);
  assign ares3 = alu_ref(aa3, ab3, ctl3);
  assign az3   = (ares3 == 32'd0);

  alu_arbiter #(.NUM_REQ(2), .XLEN(32)) d2 (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid[1:0]),
    .req_ready  (rdy2),
    .req_a      (req_a[63:0]),
    .req_b      (req_b[63:0]),
    .req_op     (req_op[7:0]),
    .alu_a      (aa2),
    .alu_b      (ab2),
    .alu_ctrl   (ctl2),
    .alu_result (ares2),
    .alu_zero   (az2),
    .rsp_valid  (rv2),
    .rsp_ready  (rsp_ready[1:0]),
    .rsp_result (res2),
    .rsp_zero   (z2)
  );

  alu_arbiter #(.NUM_REQ(3), .XLEN(32)) d3 (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (rdy3),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .alu_a      (aa3),
    .alu_b      (ab3),
    .alu_ctrl   (ctl3),
    .alu_result (ares3),
    .alu_zero   (az3),
    .rsp_valid  (rv3),
    .rsp_ready  (rsp_ready),
    .rsp_result (res3),
    .rsp_zero   (z3)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_own[k]  = -1;
      m_ptr[k]  = 0;
      m_res[k]  = '0;
      m_zero[k] = 1'b0;
      last_g[k] = -1;
    end
  endtask

  task automatic set_req(input int i, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] op);
    req_a[i*32 +: 32] = a;
    req_b[i*32 +: 32] = b;
    req_op[i*4 +: 4]  = op;
  endtask

  // Called just after a rising edge; checks mid-cycle, then
  // advances the model across the next edge.
  task automatic step();
    int g [2];
    #4;
    for (int k = 0; k < 2; k++) begin
      int n;
      bit free;
      logic [2:0] e_rdy, e_rv, o_rdy, o_rv;
      logic [31:0] e_a, e_b, o_a, o_b, o_res;
      logic [3:0] e_op, o_op;
      logic o_z;
      n = (k == 0) ? 2 : 3;
      g[k] = -1;
      free = (m_own[k] < 0) || rsp_ready[m_own[k]];
      if (free && !rst) begin
        for (int j = 0; j < n; j++) begin
          int c;
          c = (m_ptr[k] + j) % n;
          if (g[k] < 0 && req_valid[c]) g[k] = c;
        end
      end
      e_rdy = '0;
      e_a = '0;
      e_b = '0;
      e_op = 4'b0000;
      if (g[k] >= 0) begin
        e_rdy[g[k]] = 1'b1;
        e_a  = req_a[g[k]*32 +: 32];
        e_b  = req_b[g[k]*32 +: 32];
        e_op = req_op[g[k]*4 +: 4];
      end
      e_rv = '0;
      if (m_own[k] >= 0) e_rv[m_own[k]] = 1'b1;
      if (k == 0) begin
        o_rdy = {1'b0, rdy2}; o_rv = {1'b0, rv2};
        o_a = aa2; o_b = ab2; o_op = ctl2;
        o_res = res2; o_z = z2;
      end else begin
        o_rdy = rdy3; o_rv = rv3;
        o_a = aa3; o_b = ab3; o_op = ctl3;
        o_res = res3; o_z = z3;
      end
      chk($sformatf("n%0d_req_ready", n), 32'(o_rdy), 32'(e_rdy));
      chk($sformatf("n%0d_alu_a", n), o_a, e_a);
      chk($sformatf("n%0d_alu_b", n), o_b, e_b);
      chk($sformatf("n%0d_alu_ctrl", n), 32'(o_op), 32'(e_op));
      chk($sformatf("n%0d_rsp_valid", n), 32'(o_rv), 32'(e_rv));
      if (m_own[k] >= 0) begin
        chk($sformatf("n%0d_rsp_result", n), o_res, m_res[k]);
        chk($sformatf("n%0d_rsp_zero", n), 32'(o_z), 32'(m_zero[k]));
      end
      if (g[k] >= 0) begin
        m_own[k]  = g[k];
        m_res[k]  = alu_ref(e_a, e_b, e_op);
        m_zero[k] = (m_res[k] == 32'd0);
        m_ptr[k]  = (g[k] + 1) % n;
      end else if (!free) begin
        m_own[k] = m_own[k];
      end else begin
        m_own[k] = -1;
      end
      last_g[k] = g[k];
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int gexp [4];
    logic [31:0] held2, held3;
    model_reset();
    req_valid = 3'b111;
    @(posedge clk);
    #1;
    chk("rst_ready_n2", 32'(rdy2), 32'd0);
    chk("rst_ready_n3", 32'(rdy3), 32'd0);
    chk("rst_rsp_valid_n3", 32'(rv3), 32'd0);
    chk("rst_rsp_result_n2", res2, 32'd0);
    chk("rst_rsp_zero_n2", 32'(z2), 32'd0);
    rst = 1'b0;
    req_valid = '0;

    // single ADD
    set_req(0, 32'd5, 32'd7, 4'b0010);
    req_valid = 3'b001;
    rsp_ready = 3'b111;
    step();
    chk("single_grant_n2", 32'(last_g[0]), 32'd0);
    chk("single_valid_n2", 32'(rv2), 32'd1);
    chk("single_result_n2", res2, 32'd12);
    chk("single_zero_n2", 32'(z2), 32'd0);
    chk("single_result_n3", res3, 32'd12);

    // reset while a response is pending
    req_valid = 3'b011;
    rsp_ready = 3'b000;
    #1;
    chk("busy_ready_n2", 32'(rdy2), 32'd0);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_valid_n2", 32'(rv2), 32'd0);
    chk("midrst_valid_n3", 32'(rv3), 32'd0);
    chk("midrst_result_n2", res2, 32'd0);
    chk("midrst_zero_n3", 32'(z3), 32'd0);
    chk("midrst_ready_n2", 32'(rdy2), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // contention: alternate grants starting at req 0
    set_req(0, 32'd9, 32'd9, 4'b0110);
    set_req(1, 32'hF0, 32'h0F, 4'b0001);
    rsp_ready = 3'b111;
    gexp = '{0, 1, 0, 1};
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("cont_grant%0d_n2", i), 32'(last_g[0]), 32'(gexp[i]));
      chk($sformatf("cont_grant%0d_n3", i), 32'(last_g[1]), 32'(gexp[i]));
      chk($sformatf("cont_res%0d_n2", i), res2,
          (gexp[i] == 0) ? 32'd0 : 32'hFF);
      chk($sformatf("cont_zero%0d_n2", i), 32'(z2),
          (gexp[i] == 0) ? 32'd1 : 32'd0);
    end

    // backpressure
    rsp_ready = 3'b000;
    held2 = res2;
    held3 = res3;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_hold_n2", res2, held2);
      chk("bp_hold_n3", res3, held3);
      chk("bp_valid_n2", 32'(rv2), 32'd2);
    end
    rsp_ready = 3'b111;
    step();
    chk("bp_reissue_n2", 32'(rv2), 32'd1);
    chk("bp_reissue_n3", 32'(rv3), 32'd1);

    // wrap on the 3-requester instance
    set_req(2, 32'd3, 32'd4, 4'b0010);
    req_valid = 3'b100;
    step();
    chk("wrap_g0_n3", 32'(last_g[1]), 32'd2);
    req_valid = 3'b111;
    gexp = '{0, 1, 2, 0};
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("wrap_g%0d_n3", i + 1), 32'(last_g[1]), 32'(gexp[i]));
    end

    // undefined op
    req_valid = 3'b001;
    set_req(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b1111);
    step();
    chk("illegal_res_n2", res2, 32'd0);
    chk("illegal_zero_n2", 32'(z2), 32'd1);
    chk("illegal_res_n3", res3, 32'd0);
    chk("illegal_zero_n3", 32'(z3), 32'd1);
    req_valid = '0;
    step();

    // randomized traffic; requests held until some instance takes them
    for (int t = 0; t < 400; t++) begin
      for (int i = 0; i < 3; i++) begin
        if (!req_valid[i] || last_g[0] == i || last_g[1] == i) begin
          logic [3:0] op;
          case ($urandom_range(0, 4))
            0: op = 4'b0000;
            1: op = 4'b0001;
            2: op = 4'b0010;
            3: op = 4'b0110;
            default: op = 4'($urandom);
          endcase
          req_valid[i] = ($urandom_range(0, 3) != 0);
          set_req(i, $urandom, ($urandom_range(0, 3) == 0) ?
                  req_a[i*32 +: 32] : $urandom, op);
        end
      end
      rsp_ready = 3'($urandom) | ($urandom_range(0, 1) ? 3'b111 : 3'b000);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
